systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of pe instances.
- Accepts a start/k_len command, clears the array, and issues skewed per-lane reads to the A-row and B-column operand buffers.
- Drives zero-masked operand lanes into the array edge, holds array enable until the last partial product reaches every c_out, then freezes the array and flags results valid.

Parameters:
- N, 2, array dimension; number of A lanes (rows) and B lanes (columns).
- DATA_W, 8, operand width; must equal the pe data_width.
- K_MAX, 16, maximum reduction length; operand buffer depth per lane.
- AW, $clog2(K_MAX), operand buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  command request; accepted only when busy=0.
- k_len  in  AW+1  reduction length K, sampled with an accepted start.
- abort  in  1  synchronous cancel of an in-flight job.
- busy  out  1  high in CLEAR and RUN.
- done  out  1  one-cycle pulse on entry to HOLD.
- results_valid  out  1  array c_out values are final and frozen.
- array_clr  out  1  registered pulse; system ORs it into the pe rst.
- array_en  out  1  registered; drives the pe en of every array element.
- a_rd_en  out  N  per-row A buffer read enable.
- a_rd_addr  out  N*AW  per-row A read address (lane i at [i*AW +: AW]).
- a_rd_data  in  N*DATA_W  A buffer read data; 1-cycle read latency.
- a_feed  out  N*DATA_W  A operand into column 0 of row i.
- b_rd_en  out  N  per-column B buffer read enable.
- b_rd_addr  out  N*AW  per-column B read address.
- b_rd_data  in  N*DATA_W  B buffer read data; 1-cycle read latency.
- b_feed  out  N*DATA_W  B operand into row 0 of column j.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, results_valid=0, array_clr=0, array_en=0, all rd_en=0, all rd_addr=0, mask registers=0, so a_feed=b_feed=0.
- States: IDLE, CLEAR, RUN, HOLD.
  - IDLE/HOLD -> CLEAR on start. Latch K=min(k_len,K_MAX). results_valid falls immediately.
  - CLEAR lasts 1 cycle with array_clr=1 and array_en=0. It then goes to RUN with t=0, or directly to HOLD if K=0 (done pulses, results are zero).
  - RUN: array_en=1, cycle counter t counts 0..T-1 with T=K+4N. Go to HOLD after t=T-1.
  - HOLD: array_en=0, results_valid=1, done=1 in the first cycle only. Stays in HOLD until the next start.
- Skew: the pe forwards a/b with a 2-cycle hop.
  - In RUN cycle t, lane i (A and B alike) has rd_en=1 and rd_addr=t-2i when 2i <= t < 2i+K; otherwise rd_en=0 and rd_addr=0.
- Feed: per lane, register rd_en into mask_q. The feed lane equals rd_data when mask_q=1, else 0 (combinational AND). Zeros outside the window add 0 to every accumulator.
- Latency:
  - Last term reaches PE(N-1,N-1) c_out in RUN cycle K+4N relative to t=0. This is the first HOLD cycle.
  - start sampled in cycle s gives CLEAR at s+1, RUN t=0 at s+2, done at s+2+K+4N.
- Counter width: $clog2(K_MAX+4N+1).
- abort in CLEAR or RUN:
  - Next state IDLE; array_en, rd_en, and masks drop next edge; no done; results_valid=0.
  - abort in IDLE/HOLD is ignored.
  - abort and start in the same cycle: abort wins when busy; start wins when idle.
- start while busy is ignored; no queueing.
- rst mid-RUN: all outputs return to reset values asynchronously. Array state is undefined to the controller and is cleared by the next CLEAR.
- No combinational path from start or k_len to any output. Only a_feed/b_feed depend combinationally on rd_data.

Test Plan:
- N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start at cycle s -> array_clr at s+1, done at s+12, C=[[19,22],[43,50]], results_valid held until next start.
- Same job, check lane 1 -> a_rd_en[1] high RUN t=2..3 with addr 0,1; a_feed[1] nonzero only t=3..4; lane 0 rd at t=0..1.
- k_len=0 -> CLEAR then done next cycle, array_en never high, all C=0.
- k_len=20 with K_MAX=16 -> behaves as K=16, done at s+2+16+8, addresses never exceed 15.
- abort at RUN t=3 -> IDLE next cycle, array_en/rd_en=0, no done, results_valid=0; new start gives correct C=[[19,22],[43,50]].
- Back-to-back: start asserted during RUN ignored; start in the HOLD cycle of done -> new CLEAR next cycle, second job with A=B=identity gives C=identity.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
//
// Sequencer for an N x N output-stationary systolic array. One accepted
// start/k_len command clears the array, streams K operand pairs into the array
// edge with a 2-cycle-per-lane skew, keeps the array enabled until the last
// partial product has reached every c_out, then freezes the array and flags
// the results as valid.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start, k_len      job request (taken only when not busy) and reduction length
//   abort             synchronous cancel of a job in CLEAR or RUN
//   busy              high in CLEAR and RUN
//   done              one-cycle pulse on entry to HOLD
//   results_valid     array c_out values are final and frozen
//   array_clr         one-cycle clear pulse for every pe
//   array_en          enable for every pe
//   a_rd_en/addr      per-row A buffer read port (lane i at [i*AW +: AW])
//   a_rd_data         A buffer read data, 1-cycle latency
//   a_feed            zero-masked A operand into column 0 of each row
//   b_rd_en/addr      per-column B buffer read port
//   b_rd_data         B buffer read data, 1-cycle latency
//   b_feed            zero-masked B operand into row 0 of each column
// -----------------------------------------------------------------------------
module systolic_seq_ctrl #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int K_MAX  = 16,
  parameter int AW     = $clog2(K_MAX)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW:0]         k_len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                results_valid,
  output logic                array_clr,
  output logic                array_en,
  output logic [N-1:0]        a_rd_en,
  output logic [N*AW-1:0]     a_rd_addr,
  input  logic [N*DATA_W-1:0] a_rd_data,
  output logic [N*DATA_W-1:0] a_feed,
  output logic [N-1:0]        b_rd_en,
  output logic [N*AW-1:0]     b_rd_addr,
  input  logic [N*DATA_W-1:0] b_rd_data,
  output logic [N*DATA_W-1:0] b_feed
);

  localparam int KW = AW + 1;
  localparam int CW = $clog2(K_MAX + 4 * N + 1);
  // One spare bit so lane offsets can be compared without wrapping.
  localparam int LW = CW + 1;

  localparam logic [KW-1:0] K_MAX_V = KW'(K_MAX);
  // Last RUN cycle is t = K + 4N - 1.
  localparam logic [CW-1:0] T_OFS   = CW'(4 * N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     t_q, t_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rv_q, rv_d;
  logic              clr_q, clr_d;
  logic              en_q, en_d;
  logic [N-1:0]      rd_en_q, rd_en_d;
  logic [N*AW-1:0]   rd_addr_q, rd_addr_d;
  logic [N-1:0]      mask_q, mask_d;
  logic [LW-1:0]     lane_off;

  // Next-state and next-output logic. Every output is decoded from the next
  // state so it is available straight from a flop in the cycle it applies to.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    k_d       = k_q;
    t_d       = t_q;
    done_d    = 1'b0;
    rv_d      = rv_q;
    rd_en_d   = '0;
    rd_addr_d = '0;
    lane_off  = '0;

    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (start) begin
          state_d = S_CLEAR;
          k_d     = (k_len > K_MAX_V) ? K_MAX_V : k_len;
          rv_d    = 1'b0;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
          rv_d    = 1'b0;
        end else if (k_q == '0) begin
          // Nothing to reduce: the cleared array already holds the answer.
          state_d = S_HOLD;
          done_d  = 1'b1;
          rv_d    = 1'b1;
        end else begin
          state_d = S_RUN;
          t_d     = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          rv_d    = 1'b0;
        end else if (t_q == CW'(k_q) + T_OFS) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
          rv_d    = 1'b1;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    clr_d  = (state_d == S_CLEAR);
    en_d   = (state_d == S_RUN);
    busy_d = clr_d | en_d;

    // Lane i starts 2i cycles late to match the 2-cycle hop of each pe, and
    // reads K consecutive entries starting at address 0.
    if (state_d == S_RUN) begin
      for (int i = 0; i < N; i++) begin
        lane_off = LW'(t_d) - LW'(2 * i);
        if ((LW'(t_d) >= LW'(2 * i)) && (lane_off < LW'(k_q))) begin
          rd_en_d[i]              = 1'b1;
          rd_addr_d[i*AW +: AW]   = lane_off[AW-1:0];
        end
      end
    end

    // The mask tracks the read enable one cycle later, aligned with the
    // returning read data; an abort drops it together with everything else.
    mask_d = (state_d == S_IDLE) ? '0 : rd_en_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      t_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rv_q      <= 1'b0;
      clr_q     <= 1'b0;
      en_q      <= 1'b0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      mask_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the ending cycle, independent of statement order.
      state_q   <= state_d;
      k_q       <= k_d;
      t_q       <= t_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rv_q      <= rv_d;
      clr_q     <= clr_d;
      en_q      <= en_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      mask_q    <= mask_d;
    end
  end

  // Outside the read window the lanes carry zeros, which add nothing to any
  // accumulator, so the array can stay enabled across the whole RUN window.
  always_comb begin
    a_feed = '0;
    b_feed = '0;
    for (int i = 0; i < N; i++) begin
      a_feed[i*DATA_W +: DATA_W] = a_rd_data[i*DATA_W +: DATA_W] & {DATA_W{mask_q[i]}};
      b_feed[i*DATA_W +: DATA_W] = b_rd_data[i*DATA_W +: DATA_W] & {DATA_W{mask_q[i]}};
    end
  end

  // A and B lanes share one schedule.
  assign busy          = busy_q;
  assign done          = done_q;
  assign results_valid = rv_q;
  assign array_clr     = clr_q;
  assign array_en      = en_q;
  assign a_rd_en       = rd_en_q;
  assign b_rd_en       = rd_en_q;
  assign a_rd_addr     = rd_addr_q;
  assign b_rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
//
// Drives systolic_seq_ctrl with directed and random jobs. Operand buffers are
// modelled as 1-cycle-latency memories that return junk when not read, and the
// array is modelled as an N x N grid of accumulators fed through 2-cycle hops.
// Final accumulator values are compared with a plain matrix product.
// -----------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

  localparam int N      = 2;
  localparam int DATA_W = 8;
  localparam int K_MAX  = 16;
  localparam int AW     = $clog2(K_MAX);
  localparam int HD     = 2 * N;

  logic                clk;
  logic                rst;
  logic                start;
  logic [AW:0]         k_len;
  logic                abort;
  logic                busy, done, results_valid, array_clr, array_en;
  logic [N-1:0]        a_rd_en, b_rd_en;
  logic [N*AW-1:0]     a_rd_addr, b_rd_addr;
  logic [N*DATA_W-1:0] a_rd_data, b_rd_data;
  logic [N*DATA_W-1:0] a_feed, b_feed;

  systolic_seq_ctrl #(
    .N(N), .DATA_W(DATA_W), .K_MAX(K_MAX), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .results_valid(results_valid),
    .array_clr(array_clr), .array_en(array_en),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data), .a_feed(a_feed),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data), .b_feed(b_feed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Operand buffers: a_mem[i] is row i of A, b_mem[j] is column j of B.
  logic [DATA_W-1:0] a_mem [N][K_MAX];
  logic [DATA_W-1:0] b_mem [N][K_MAX];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (a_rd_en[i]) a_rd_data[i*DATA_W +: DATA_W] <= a_mem[i][a_rd_addr[i*AW +: AW]];
      else            a_rd_data[i*DATA_W +: DATA_W] <= DATA_W'($urandom);
      if (b_rd_en[i]) b_rd_data[i*DATA_W +: DATA_W] <= b_mem[i][b_rd_addr[i*AW +: AW]];
      else            b_rd_data[i*DATA_W +: DATA_W] <= DATA_W'($urandom);
    end
  end

  // Array model: the operand at PE(i,j) is the row-i feed delayed 2j enabled
  // cycles and the column-j feed delayed 2i enabled cycles.
  int                acc [N][N];
  logic [DATA_W-1:0] ah  [N][HD];
  logic [DATA_W-1:0] bh  [N][HD];

  function automatic int a_at(input int i, input int dly);
    if (dly == 0) return int'(a_feed[i*DATA_W +: DATA_W]);
    return int'(ah[i][dly-1]);
  endfunction

  function automatic int b_at(input int j, input int dly);
    if (dly == 0) return int'(b_feed[j*DATA_W +: DATA_W]);
    return int'(bh[j][dly-1]);
  endfunction

  always @(posedge clk) begin
    if (array_clr) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) acc[i][j] <= 0;
        for (int d = 0; d < HD; d++) begin
          ah[i][d] <= '0;
          bh[i][d] <= '0;
        end
      end
    end else if (array_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= acc[i][j] + a_at(i, 2 * j) * b_at(j, 2 * i);
      for (int i = 0; i < N; i++) begin
        ah[i][0] <= a_feed[i*DATA_W +: DATA_W];
        bh[i][0] <= b_feed[i*DATA_W +: DATA_W];
        for (int d = 1; d < HD; d++) begin
          ah[i][d] <= ah[i][d-1];
          bh[i][d] <= bh[i][d-1];
        end
      end
    end
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs outside CLEAR/RUN: nothing read, nothing fed, array frozen.
  task automatic check_quiet(input string p, input logic exp_done, input logic exp_rv);
    check({p, "_busy"},  busy, 1'b0);
    check({p, "_done"},  done, exp_done);
    check({p, "_rv"},    results_valid, exp_rv);
    check({p, "_clr"},   array_clr, 1'b0);
    check({p, "_en"},    array_en, 1'b0);
    check({p, "_arden"}, a_rd_en, '0);
    check({p, "_brden"}, b_rd_en, '0);
    check({p, "_aaddr"}, a_rd_addr, '0);
    check({p, "_baddr"}, b_rd_addr, '0);
    check({p, "_afeed"}, a_feed, '0);
    check({p, "_bfeed"}, b_feed, '0);
  endtask

  // RUN cycle t of a job with reduction length kk: lane i reads entry t-2i
  // during [2i, 2i+kk) and that entry appears on the feed one cycle later.
  task automatic check_run_cycle(input int t, input int kk);
    logic [N-1:0]        e_en;
    logic [N*AW-1:0]     e_addr;
    logic [N*DATA_W-1:0] e_af, e_bf;
    e_en = '0; e_addr = '0; e_af = '0; e_bf = '0;
    for (int i = 0; i < N; i++) begin
      if (t >= 2 * i && t < 2 * i + kk) begin
        e_en[i] = 1'b1;
        e_addr[i*AW +: AW] = AW'(t - 2 * i);
      end
      if (t >= 2 * i + 1 && t <= 2 * i + kk) begin
        e_af[i*DATA_W +: DATA_W] = a_mem[i][t - 1 - 2 * i];
        e_bf[i*DATA_W +: DATA_W] = b_mem[i][t - 1 - 2 * i];
      end
    end
    check($sformatf("run%0d_en", t),    array_en, 1'b1);
    check($sformatf("run%0d_busy", t),  busy, 1'b1);
    check($sformatf("run%0d_done", t),  done, 1'b0);
    check($sformatf("run%0d_rv", t),    results_valid, 1'b0);
    check($sformatf("run%0d_clr", t),   array_clr, 1'b0);
    check($sformatf("run%0d_arden", t), a_rd_en, e_en);
    check($sformatf("run%0d_brden", t), b_rd_en, e_en);
    check($sformatf("run%0d_aaddr", t), a_rd_addr, e_addr);
    check($sformatf("run%0d_baddr", t), b_rd_addr, e_addr);
    check($sformatf("run%0d_afeed", t), a_feed, e_af);
    check($sformatf("run%0d_bfeed", t), b_feed, e_bf);
  endtask

  task automatic check_clear_cycle();
    check("clr_pulse", array_clr, 1'b1);
    check("clr_en",    array_en, 1'b0);
    check("clr_busy",  busy, 1'b1);
    check("clr_rv",    results_valid, 1'b0);
    check("clr_done",  done, 1'b0);
  endtask

  // Called at a falling edge; start is sampled at the next rising edge
  // (cycle s). Returns at the falling edge of the done cycle s+2+K+4N.
  task automatic run_job(input int kl, input bit abort_with_start, input bit start_while_busy);
    int kk, tt, e;
    kk = (kl > K_MAX) ? K_MAX : kl;
    tt = kk + 4 * N;
    start = 1'b1;
    k_len = (AW+1)'(kl);
    abort = abort_with_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_clear_cycle();
    if (kk > 0) begin
      for (int t = 0; t < tt; t++) begin
        @(negedge clk);
        check_run_cycle(t, kk);
        if (start_while_busy && t == 1) begin
          start = 1'b1;
          k_len = (AW+1)'($urandom_range(0, K_MAX));
        end
        if (t == 2) start = 1'b0;
      end
    end
    @(negedge clk);
    check_quiet("hold0", 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        e = 0;
        for (int k = 0; k < kk; k++) e += int'(a_mem[i][k]) * int'(b_mem[j][k]);
        check($sformatf("c%0d%0d_k%0d", i, j, kk), acc[i][j], e);
      end
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        a_mem[i][k] = DATA_W'($urandom);
        b_mem[i][k] = DATA_W'($urandom);
      end
  endtask

  // A=[[1,2],[3,4]], B=[[5,6],[7,8]]; entries past K stay random.
  task automatic load_fixed();
    load_random();
    a_mem[0][0] = 1; a_mem[0][1] = 2;
    a_mem[1][0] = 3; a_mem[1][1] = 4;
    b_mem[0][0] = 5; b_mem[0][1] = 7;
    b_mem[1][0] = 6; b_mem[1][1] = 8;
  endtask

  task automatic load_identity();
    load_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_mem[i][k] = (i == k) ? 1 : 0;
        b_mem[i][k] = (i == k) ? 1 : 0;
      end
  endtask

  task automatic idle_cycles(input int n, input logic exp_rv);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_quiet("idle", 1'b0, exp_rv);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    k_len = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset", 1'b0, 1'b0);
    rst = 1'b0;
    idle_cycles(2, 1'b0);

    // Basic 2x2 job, plus results held while idle.
    load_fixed();
    run_job(2, 1'b0, 1'b0);
    check("lit_c00", acc[0][0], 19);
    check("lit_c01", acc[0][1], 22);
    check("lit_c10", acc[1][0], 43);
    check("lit_c11", acc[1][1], 50);
    idle_cycles(3, 1'b1);

    // Empty reduction: CLEAR then straight to HOLD with a zero array.
    load_random();
    run_job(0, 1'b0, 1'b0);
    idle_cycles(1, 1'b1);

    // Oversized k_len saturates at K_MAX.
    load_random();
    run_job(K_MAX + 4, 1'b0, 1'b0);
    idle_cycles(1, 1'b1);

    // Abort at RUN t=3 with a competing start; abort wins while busy.
    load_random();
    start = 1'b1;
    k_len = (AW+1)'(2);
    @(negedge clk);
    start = 1'b0;
    check_clear_cycle();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check_run_cycle(t, 2);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check_quiet("abort", 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    load_fixed();
    run_job(2, 1'b0, 1'b0);
    check("post_abort_c11", acc[1][1], 50);

    // Start during RUN ignored; start in the done cycle chains a second job,
    // and abort alongside that start is ignored since the block is not busy.
    idle_cycles(1, 1'b1);
    load_fixed();
    run_job(2, 1'b0, 1'b1);
    load_identity();
    run_job(2, 1'b1, 1'b0);
    check("ident_c00", acc[0][0], 1);
    check("ident_c01", acc[0][1], 0);
    check("ident_c11", acc[1][1], 1);
    idle_cycles(2, 1'b1);

    // Asynchronous reset in the middle of RUN.
    load_random();
    start = 1'b1;
    k_len = (AW+1)'(6);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("rst_mid", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2, 1'b0);

    // Random jobs, some chained directly off the done cycle.
    for (int r = 0; r < 6; r++) begin
      load_random();
      run_job($urandom_range(0, K_MAX + 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2), 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
